icache_line_refill: RTL and testbench
=====================================

Name: icache_line_refill

Overview:
- Instruction-cache refill engine that acts as the write-side driver of the cache's dual-port line memory.
- Accepts a miss address from the fetch/lookup logic and issues one line-aligned read request to the next memory level.
- Collects BEAT_WIDTH response beats into a full LINE_WIDTH line, then writes it in a single cycle through the memory's WRITE_ADDRESS / DATA_IN / WRITE_ENABLE port, with the tag for the tag array.
- Handles one outstanding miss at a time.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- LINE_WIDTH, 512, cache line width in bits; must be a multiple of BEAT_WIDTH and of 8.
- BEAT_WIDTH, 32, lower-level response data width.
- MEMORY_DEPTH, 512, number of lines; INDEX_WIDTH = $clog2(MEMORY_DEPTH).
- Derived values:
  - OFFSET_WIDTH = $clog2(LINE_WIDTH/8) (6 at defaults).
  - BEATS = LINE_WIDTH/BEAT_WIDTH (16 at defaults).
  - TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (17 at defaults).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- MISS_VALID  in  1  miss request valid.
- MISS_READY  out  1  engine can accept a miss.
- MISS_ADDRESS  in  ADDR_WIDTH  missing fetch byte address.
- MEM_REQ_VALID  out  1  read request to lower level valid.
- MEM_REQ_READY  in  1  lower level accepts request.
- MEM_REQ_ADDRESS  out  ADDR_WIDTH  line-aligned request address (offset bits zero).
- MEM_RESP_VALID  in  1  response beat valid (no backpressure; engine always accepts in COLLECT).
- MEM_RESP_DATA  in  BEAT_WIDTH  response beat.
- MEM_RESP_ERROR  in  1  beat carries bus error.
- WRITE_ADDRESS  out  INDEX_WIDTH  line index to line memory.
- DATA_IN  out  LINE_WIDTH  assembled line to line memory.
- WRITE_ENABLE  out  1  one-cycle line write strobe.
- TAG_OUT  out  TAG_WIDTH  tag of the written line, valid with WRITE_ENABLE.
- REFILL_DONE  out  1  one-cycle pulse, coincident with WRITE_ENABLE.
- REFILL_ERROR  out  1  one-cycle pulse, refill aborted by error.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset, while RESETN low:
  - State goes to IDLE and the beat counter clears.
  - MISS_READY = 0; all other outputs are 0, including DATA_IN and the addresses.
  - Reset mid-refill discards the partial line and never produces WRITE_ENABLE.
- States: IDLE, REQUEST, COLLECT, WRITE, ERROR.
- IDLE:
  - MISS_READY = 1 (combinational state==IDLE gated by RESETN).
  - On MISS_VALID & MISS_READY, register MISS_ADDRESS: index = addr[OFFSET_WIDTH +: INDEX_WIDTH], tag = upper TAG_WIDTH bits.
  - Then go to REQUEST.
- REQUEST:
  - MEM_REQ_VALID = 1 and MEM_REQ_ADDRESS = {tag, index, OFFSET zeros}; both held stable until MEM_REQ_READY.
  - On handshake go to COLLECT with beat counter = 0.
  - MEM_RESP_VALID in REQUEST, including the handshake cycle, is ignored.
- COLLECT:
  - Each MEM_RESP_VALID cycle stores beat k at line bits [k*BEAT_WIDTH +: BEAT_WIDTH] (beat 0 = LSBs) and increments k.
  - Gaps of any length between beats are allowed.
  - When the beat with k = BEATS-1 is accepted, the counter wraps to 0 and the state goes to WRITE.
  - A beat with MEM_RESP_ERROR = 1 goes to ERROR instead; the beat is not stored.
- WRITE (exactly 1 cycle):
  - WRITE_ENABLE = 1 and REFILL_DONE = 1.
  - WRITE_ADDRESS = index, TAG_OUT = tag, DATA_IN = assembled line.
  - Next state IDLE.
- ERROR (exactly 1 cycle):
  - REFILL_ERROR = 1 and WRITE_ENABLE = 0.
  - The engine does not drain remaining beats; the lower level must stop the burst after an error beat.
  - Next state IDLE.
- Outside WRITE:
  - WRITE_ENABLE = 0.
  - WRITE_ADDRESS / TAG_OUT / DATA_IN hold their last values; they are only meaningful with WRITE_ENABLE.
- Latency with MEM_REQ_READY held 1 and back-to-back beats (miss accepted at edge 0):
  - MEM_REQ_VALID in cycle 1.
  - Beats accepted in cycles 2..BEATS+1.
  - WRITE_ENABLE in cycle BEATS+2 (18 at defaults).
- Next miss: MISS_VALID during WRITE or ERROR is not accepted; the earliest next acceptance is the cycle after WRITE or ERROR.
- Extra beats: a MEM_RESP_VALID arriving in IDLE, WRITE or ERROR is ignored.

Test Plan:
- Reset, then miss at 0x8001_2FC4 with READY = 1 and 16 back-to-back beats 0x0..0xF.
  - Required: MEM_REQ_ADDRESS = 0x8001_2FC0.
  - Required: WRITE_ENABLE is high exactly once, 18 cycles after acceptance, with WRITE_ADDRESS = 0x0BF and TAG_OUT = 0x10002.
  - Required: DATA_IN[31:0] = 0, DATA_IN[511:480] = 0xF, and REFILL_DONE is high in the same cycle.
- MEM_REQ_READY held low for 5 cycles.
  - Required: MEM_REQ_VALID and MEM_REQ_ADDRESS are stable throughout.
  - Required: a response beat driven in the handshake cycle is not captured; the line is built from the next 16 beats.
- Random 0–3 cycle gaps between beats.
  - Required: the line contents are identical to the back-to-back case, and there is one WRITE_ENABLE.
- MEM_RESP_ERROR on beat 7.
  - Required: REFILL_ERROR pulses 1 cycle later, WRITE_ENABLE never rises, and MISS_READY = 1 on the following cycle.
- RESETN pulsed low after beat 9.
  - Required: all outputs go to 0 immediately and no write occurs.
  - Required: a new miss at 0x0000_1234 refills index 0x048 with tag 0x00000.
- MISS_VALID held high continuously for two different addresses.
  - Required: the second miss is accepted exactly 1 cycle after the first WRITE_ENABLE cycle, and BUSY is low only in that cycle.

Source files
------------

// File: rtl/icache_line_refill.sv
// Instruction-cache line refill engine: turns one miss into a line-aligned
// burst read, assembles the beats and writes the full line in a single cycle.
module icache_line_refill #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 512,
  parameter int BEAT_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 512,
  localparam int INDEX_WIDTH  = $clog2(MEMORY_DEPTH),
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8),
  localparam int BEATS        = LINE_WIDTH / BEAT_WIDTH,
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   MISS_VALID,
  output logic                   MISS_READY,
  input  logic [ADDR_WIDTH-1:0]  MISS_ADDRESS,
  output logic                   MEM_REQ_VALID,
  input  logic                   MEM_REQ_READY,
  output logic [ADDR_WIDTH-1:0]  MEM_REQ_ADDRESS,
  input  logic                   MEM_RESP_VALID,
  input  logic [BEAT_WIDTH-1:0]  MEM_RESP_DATA,
  input  logic                   MEM_RESP_ERROR,
  output logic [INDEX_WIDTH-1:0] WRITE_ADDRESS,
  output logic [LINE_WIDTH-1:0]  DATA_IN,
  output logic                   WRITE_ENABLE,
  output logic [TAG_WIDTH-1:0]   TAG_OUT,
  output logic                   REFILL_DONE,
  output logic                   REFILL_ERROR,
  output logic                   BUSY
);

  localparam int COUNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [COUNT_WIDTH-1:0] LAST_BEAT = COUNT_WIDTH'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_WIDTH) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    COLLECT,
    WRITE,
    ERROR
  } state_t;

  state_t                   state;
  logic [COUNT_WIDTH-1:0]   beat_count;
  logic [LINE_WIDTH-1:0]    line_buf;
  logic [LINE_WIDTH-1:0]    next_line;
  logic [INDEX_WIDTH-1:0]   line_index;
  logic [TAG_WIDTH-1:0]     line_tag;

  // The aligned request address doubles as the stored index/tag of the miss.
  assign line_index = MEM_REQ_ADDRESS[OFFSET_WIDTH +: INDEX_WIDTH];
  assign line_tag   = MEM_REQ_ADDRESS[ADDR_WIDTH-1 -: TAG_WIDTH];

  assign MISS_READY = (state == IDLE) && RESETN;

  always_comb begin
    next_line = line_buf;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_count == COUNT_WIDTH'(k)) begin
        next_line[k*BEAT_WIDTH +: BEAT_WIDTH] = MEM_RESP_DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state           <= IDLE;
      beat_count      <= '0;
      line_buf        <= '0;
      MEM_REQ_VALID   <= 1'b0;
      MEM_REQ_ADDRESS <= '0;
      WRITE_ADDRESS   <= '0;
      DATA_IN         <= '0;
      WRITE_ENABLE    <= 1'b0;
      TAG_OUT         <= '0;
      REFILL_DONE     <= 1'b0;
      REFILL_ERROR    <= 1'b0;
      BUSY            <= 1'b0;
    end else begin
      WRITE_ENABLE <= 1'b0;
      REFILL_DONE  <= 1'b0;
      REFILL_ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (MISS_VALID) begin
            MEM_REQ_ADDRESS <= MISS_ADDRESS & LINE_MASK;
            MEM_REQ_VALID   <= 1'b1;
            BUSY            <= 1'b1;
            state           <= REQUEST;
          end
        end
        REQUEST: begin
          if (MEM_REQ_READY) begin
            MEM_REQ_VALID <= 1'b0;
            beat_count    <= '0;
            state         <= COLLECT;
          end
        end
        COLLECT: begin
          // An error beat aborts without touching the partial line.
          if (MEM_RESP_VALID) begin
            if (MEM_RESP_ERROR) begin
              beat_count   <= '0;
              REFILL_ERROR <= 1'b1;
              state        <= ERROR;
            end else begin
              line_buf <= next_line;
              if (beat_count == LAST_BEAT) begin
                beat_count    <= '0;
                DATA_IN       <= next_line;
                WRITE_ADDRESS <= line_index;
                TAG_OUT       <= line_tag;
                WRITE_ENABLE  <= 1'b1;
                REFILL_DONE   <= 1'b1;
                state         <= WRITE;
              end else begin
                beat_count <= beat_count + COUNT_WIDTH'(1);
              end
            end
          end
        end
        WRITE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        ERROR: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line_refill.sv
// Scenario bench for icache_line_refill: scripted lower-level responder,
// per-cycle output history and a behavioural model of the refilled line.
module tb_icache_line_refill;

  localparam int HIST = 4096;

  logic         CLK = 1'b0;
  logic         RESETN;
  logic         MISS_VALID;
  logic         MISS_READY;
  logic [31:0]  MISS_ADDRESS;
  logic         MEM_REQ_VALID;
  logic         MEM_REQ_READY;
  logic [31:0]  MEM_REQ_ADDRESS;
  logic         MEM_RESP_VALID;
  logic [31:0]  MEM_RESP_DATA;
  logic         MEM_RESP_ERROR;
  logic [8:0]   WRITE_ADDRESS;
  logic [511:0] DATA_IN;
  logic         WRITE_ENABLE;
  logic [16:0]  TAG_OUT;
  logic         REFILL_DONE;
  logic         REFILL_ERROR;
  logic         BUSY;

  always #5 CLK = ~CLK;

  icache_line_refill dut (
    .CLK             (CLK),
    .RESETN          (RESETN),
    .MISS_VALID      (MISS_VALID),
    .MISS_READY      (MISS_READY),
    .MISS_ADDRESS    (MISS_ADDRESS),
    .MEM_REQ_VALID   (MEM_REQ_VALID),
    .MEM_REQ_READY   (MEM_REQ_READY),
    .MEM_REQ_ADDRESS (MEM_REQ_ADDRESS),
    .MEM_RESP_VALID  (MEM_RESP_VALID),
    .MEM_RESP_DATA   (MEM_RESP_DATA),
    .MEM_RESP_ERROR  (MEM_RESP_ERROR),
    .WRITE_ADDRESS   (WRITE_ADDRESS),
    .DATA_IN         (DATA_IN),
    .WRITE_ENABLE    (WRITE_ENABLE),
    .TAG_OUT         (TAG_OUT),
    .REFILL_DONE     (REFILL_DONE),
    .REFILL_ERROR    (REFILL_ERROR),
    .BUSY            (BUSY)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0]  beat_data [16];
  logic         h_req_valid [HIST];
  logic [31:0]  h_req_addr  [HIST];
  logic         h_done      [HIST];
  logic         h_err       [HIST];
  logic         h_busy      [HIST];
  logic         h_ready     [HIST];
  int           we_cyc  [$];
  logic [8:0]   we_addr [$];
  logic [16:0]  we_tag  [$];
  logic [511:0] we_data [$];

  // Inputs change 1 time unit after the edge, outputs are recorded at 2.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    #2;
    if (cyc < HIST) begin
      h_req_valid[cyc] = MEM_REQ_VALID;
      h_req_addr[cyc]  = MEM_REQ_ADDRESS;
      h_done[cyc]      = REFILL_DONE;
      h_err[cyc]       = REFILL_ERROR;
      h_busy[cyc]      = BUSY;
      h_ready[cyc]     = MISS_READY;
    end
    if (WRITE_ENABLE === 1'b1) begin
      we_cyc.push_back(cyc);
      we_addr.push_back(WRITE_ADDRESS);
      we_tag.push_back(TAG_OUT);
      we_data.push_back(DATA_IN);
    end
  end

  function automatic logic [31:0] model_aligned(input logic [31:0] a);
    return a - (a % 32'd64);
  endfunction

  function automatic logic [8:0] model_index(input logic [31:0] a);
    return 9'((a / 32'd64) % 32'd512);
  endfunction

  function automatic logic [16:0] model_tag(input logic [31:0] a);
    return 17'(a / 32'd32768);
  endfunction

  function automatic logic [511:0] model_line();
    logic [511:0] line;
    line = '0;
    for (int k = 0; k < 16; k++) line = line | (512'(beat_data[k]) << (32 * k));
    return line;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    we_cyc.delete();
    we_addr.delete();
    we_tag.delete();
    we_data.delete();
  endtask

  task automatic fill_counting();
    for (int k = 0; k < 16; k++) beat_data[k] = 32'(k);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++) beat_data[k] = $urandom;
  endtask

  // Scripted responder: miss in cycle P, request in P+1 (stalled ready_delay
  // cycles), beats from the cycle after the handshake.
  task automatic drive_refill(input logic [31:0] addr, input int ready_delay,
                              input int max_gap, input int err_beat,
                              input int stop_after, input bit junk,
                              output int acc_cycle, output int last_beat_cycle);
    MISS_ADDRESS = addr;
    MISS_VALID   = 1'b1;
    acc_cycle    = cyc;
    tick();
    MISS_VALID   = 1'b0;
    MISS_ADDRESS = $urandom;
    if (ready_delay > 0) begin
      MEM_REQ_READY = 1'b0;
      repeat (ready_delay) tick();
      MEM_REQ_READY = 1'b1;
    end
    if (junk) begin
      MEM_RESP_VALID = 1'b1;
      MEM_RESP_DATA  = 32'hDEAD_BEEF ^ $urandom;
    end
    tick();
    MEM_RESP_VALID  = 1'b0;
    last_beat_cycle = -1;
    for (int k = 0; k < 16; k++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) tick();
      MEM_RESP_VALID  = 1'b1;
      MEM_RESP_DATA   = beat_data[k];
      MEM_RESP_ERROR  = (k == err_beat);
      last_beat_cycle = cyc;
      tick();
      MEM_RESP_VALID  = 1'b0;
      MEM_RESP_ERROR  = 1'b0;
      MEM_RESP_DATA   = $urandom;
      if (k == err_beat || k == stop_after) break;
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (2) tick();
    checks++; if (MISS_READY !== 1'b0) begin errors++; $display("FAIL reset_miss_ready: got %b expected 0", MISS_READY); end
    checks++; if (MEM_REQ_VALID !== 1'b0 || MEM_REQ_ADDRESS !== 32'h0) begin errors++; $display("FAIL reset_req: got valid %b addr %h expected 0/0", MEM_REQ_VALID, MEM_REQ_ADDRESS); end
    checks++; if (WRITE_ENABLE !== 1'b0 || DATA_IN !== 512'h0 || WRITE_ADDRESS !== 9'h0 || TAG_OUT !== 17'h0) begin errors++; $display("FAIL reset_write_port: got we %b addr %h tag %h expected all zero", WRITE_ENABLE, WRITE_ADDRESS, TAG_OUT); end
    checks++; if (BUSY !== 1'b0 || REFILL_DONE !== 1'b0 || REFILL_ERROR !== 1'b0) begin errors++; $display("FAIL reset_status: got busy %b done %b err %b expected 0", BUSY, REFILL_DONE, REFILL_ERROR); end
    RESETN = 1'b1;
    MEM_REQ_READY = 1'b1;
    tick();
    checks++; if (MISS_READY !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL reset_release: got ready %b busy %b expected 1/0", MISS_READY, BUSY); end
  endtask

  task automatic test_basic();
    int p, lb;
    logic [31:0] a;
    logic [511:0] exp_line;
    clear_log();
    fill_counting();
    a = 32'h8001_2FC4;
    exp_line = model_line();
    drive_refill(a, 0, 0, -1, -1, 1'b0, p, lb);
    repeat (3) tick();
    checks++; if (h_req_valid[p+1] !== 1'b1 || h_req_addr[p+1] !== model_aligned(a)) begin errors++; $display("FAIL basic_request: got valid %b addr %h expected 1 %h", h_req_valid[p+1], h_req_addr[p+1], model_aligned(a)); end
    checks++; if (h_req_valid[p+2] !== 1'b0) begin errors++; $display("FAIL basic_request_drop: got %b expected 0", h_req_valid[p+2]); end
    checks++;
    if (we_cyc.size() != 1) begin
      errors++; $display("FAIL basic_we_count: got %0d expected 1", we_cyc.size());
    end else begin
      checks++; if (we_cyc[0] != p + 18) begin errors++; $display("FAIL basic_we_cycle: got %0d expected %0d", we_cyc[0] - p, 18); end
      checks++; if (we_addr[0] !== model_index(a) || we_addr[0] !== 9'h0BF) begin errors++; $display("FAIL basic_index: got %h expected 0bf", we_addr[0]); end
      checks++; if (we_tag[0] !== model_tag(a) || we_tag[0] !== 17'h10002) begin errors++; $display("FAIL basic_tag: got %h expected 10002", we_tag[0]); end
      checks++; if (we_data[0][31:0] !== 32'h0 || we_data[0][511:480] !== 32'hF) begin errors++; $display("FAIL basic_edge_beats: got %h/%h expected 0/f", we_data[0][31:0], we_data[0][511:480]); end
      checks++; if (we_data[0] !== exp_line) begin errors++; $display("FAIL basic_line: got %h expected %h", we_data[0], exp_line); end
      checks++; if (h_done[we_cyc[0]] !== 1'b1 || h_done[we_cyc[0]+1] !== 1'b0) begin errors++; $display("FAIL basic_done: got %b%b expected 10", h_done[we_cyc[0]], h_done[we_cyc[0]+1]); end
    end
  endtask

  task automatic test_ready_stall();
    int p, lb, bad;
    logic [31:0] a;
    logic [511:0] exp_line;
    clear_log();
    fill_random();
    a = $urandom;
    exp_line = model_line();
    drive_refill(a, 5, 0, -1, -1, 1'b1, p, lb);
    repeat (3) tick();
    bad = 0;
    for (int c = p + 1; c <= p + 6; c++)
      if (h_req_valid[c] !== 1'b1 || h_req_addr[c] !== model_aligned(a)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles expected 0 (addr %h)", bad, model_aligned(a)); end
    checks++; if (h_req_valid[p+7] !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", h_req_valid[p+7]); end
    checks++;
    if (we_cyc.size() != 1) begin
      errors++; $display("FAIL stall_we_count: got %0d expected 1", we_cyc.size());
    end else begin
      checks++; if (we_data[0] !== exp_line) begin errors++; $display("FAIL stall_line: got %h expected %h", we_data[0], exp_line); end
      checks++; if (we_cyc[0] != p + 23) begin errors++; $display("FAIL stall_we_cycle: got %0d expected 23", we_cyc[0] - p); end
    end
  endtask

  task automatic test_gaps();
    int p, lb;
    logic [31:0] a;
    logic [511:0] exp_line;
    clear_log();
    fill_counting();
    a = $urandom;
    exp_line = model_line();
    drive_refill(a, 0, 3, -1, -1, 1'b0, p, lb);
    repeat (3) tick();
    checks++;
    if (we_cyc.size() != 1) begin
      errors++; $display("FAIL gaps_we_count: got %0d expected 1", we_cyc.size());
    end else begin
      checks++; if (we_data[0] !== exp_line) begin errors++; $display("FAIL gaps_line: got %h expected %h", we_data[0], exp_line); end
      checks++; if (we_addr[0] !== model_index(a) || we_tag[0] !== model_tag(a)) begin errors++; $display("FAIL gaps_index_tag: got %h/%h expected %h/%h", we_addr[0], we_tag[0], model_index(a), model_tag(a)); end
      checks++; if (we_cyc[0] != lb + 1) begin errors++; $display("FAIL gaps_we_cycle: got %0d expected %0d", we_cyc[0], lb + 1); end
    end
  endtask

  task automatic test_error();
    int p, x;
    logic [31:0] a;
    clear_log();
    fill_random();
    a = $urandom;
    drive_refill(a, 0, 0, 7, -1, 1'b0, p, x);
    MEM_RESP_VALID = 1'b1;
    repeat (2) tick();
    MEM_RESP_VALID = 1'b0;
    repeat (3) tick();
    checks++; if (x != p + 9) begin errors++; $display("FAIL error_beat_cycle: got %0d expected 9", x - p); end
    checks++; if (h_err[x] !== 1'b0 || h_err[x+1] !== 1'b1 || h_err[x+2] !== 1'b0) begin errors++; $display("FAIL error_pulse: got %b%b%b expected 010", h_err[x], h_err[x+1], h_err[x+2]); end
    checks++; if (h_ready[x+1] !== 1'b0 || h_ready[x+2] !== 1'b1 || h_busy[x+2] !== 1'b0) begin errors++; $display("FAIL error_recover: got ready %b%b busy %b expected 01 0", h_ready[x+1], h_ready[x+2], h_busy[x+2]); end
    checks++; if (we_cyc.size() != 0) begin errors++; $display("FAIL error_no_write: got %0d writes expected 0", we_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int p, lb;
    logic [31:0] a;
    logic [511:0] exp_line;
    clear_log();
    fill_random();
    drive_refill($urandom, 0, 0, -1, 9, 1'b0, p, lb);
    RESETN = 1'b0;
    #2;
    checks++; if (MISS_READY !== 1'b0 || MEM_REQ_VALID !== 1'b0 || MEM_REQ_ADDRESS !== 32'h0 || BUSY !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got ready %b valid %b addr %h busy %b expected zeros", MISS_READY, MEM_REQ_VALID, MEM_REQ_ADDRESS, BUSY); end
    checks++; if (WRITE_ENABLE !== 1'b0 || DATA_IN !== 512'h0 || WRITE_ADDRESS !== 9'h0 || TAG_OUT !== 17'h0 || REFILL_DONE !== 1'b0 || REFILL_ERROR !== 1'b0) begin errors++; $display("FAIL midreset_write_port: got we %b addr %h tag %h expected zeros", WRITE_ENABLE, WRITE_ADDRESS, TAG_OUT); end
    MEM_RESP_VALID = 1'b1;
    repeat (2) tick();
    MEM_RESP_VALID = 1'b0;
    RESETN = 1'b1;
    repeat (8) tick();
    checks++; if (we_cyc.size() != 0) begin errors++; $display("FAIL midreset_no_write: got %0d writes expected 0", we_cyc.size()); end
    fill_random();
    a = 32'h0000_1234;
    exp_line = model_line();
    drive_refill(a, 0, 0, -1, -1, 1'b0, p, lb);
    repeat (3) tick();
    checks++;
    if (we_cyc.size() != 1) begin
      errors++; $display("FAIL midreset_refill_count: got %0d expected 1", we_cyc.size());
    end else begin
      checks++; if (we_addr[0] !== 9'h048 || we_tag[0] !== 17'h0) begin errors++; $display("FAIL midreset_index_tag: got %h/%h expected 048/00000", we_addr[0], we_tag[0]); end
      checks++; if (we_data[0] !== exp_line) begin errors++; $display("FAIL midreset_line: got %h expected %h", we_data[0], exp_line); end
    end
  endtask

  task automatic test_back_to_back();
    int p, bad;
    logic [31:0] a, b;
    logic [511:0] exp_a, exp_b;
    clear_log();
    a = $urandom;
    b = a ^ 32'h0040_1040;
    fill_random();
    exp_a = model_line();
    p = cyc;
    MISS_VALID = 1'b1;
    MISS_ADDRESS = a;
    tick();
    MISS_ADDRESS = b;
    tick();
    for (int k = 0; k < 16; k++) begin
      MEM_RESP_VALID = 1'b1;
      MEM_RESP_DATA = beat_data[k];
      tick();
    end
    fill_random();
    exp_b = model_line();
    MEM_RESP_DATA = $urandom;
    repeat (2) tick();
    MEM_RESP_VALID = 1'b0;
    MISS_VALID = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      MEM_RESP_VALID = 1'b1;
      MEM_RESP_DATA = beat_data[k];
      tick();
    end
    MEM_RESP_VALID = 1'b0;
    repeat (3) tick();
    bad = 0;
    for (int c = p + 1; c <= p + 37; c++)
      if (h_busy[c] !== (c != p + 19)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_busy: got %0d wrong cycles expected 0", bad); end
    checks++; if (h_ready[p+18] !== 1'b0 || h_ready[p+19] !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b%b expected 01", h_ready[p+18], h_ready[p+19]); end
    checks++; if (h_req_valid[p+20] !== 1'b1 || h_req_addr[p+20] !== model_aligned(b)) begin errors++; $display("FAIL b2b_second_req: got %b %h expected 1 %h", h_req_valid[p+20], h_req_addr[p+20], model_aligned(b)); end
    checks++;
    if (we_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_we_count: got %0d expected 2", we_cyc.size());
    end else begin
      checks++; if (we_cyc[0] != p + 18 || we_cyc[1] != p + 37) begin errors++; $display("FAIL b2b_we_cycles: got %0d/%0d expected 18/37", we_cyc[0] - p, we_cyc[1] - p); end
      checks++; if (we_data[0] !== exp_a || we_data[1] !== exp_b) begin errors++; $display("FAIL b2b_lines: got %h expected %h", we_data[1], exp_b); end
      checks++; if (we_addr[1] !== model_index(b) || we_tag[1] !== model_tag(b) || we_addr[0] !== model_index(a)) begin errors++; $display("FAIL b2b_index_tag: got %h/%h expected %h/%h", we_addr[1], we_tag[1], model_index(b), model_tag(b)); end
    end
  endtask

  initial begin
    RESETN         = 1'b0;
    MISS_VALID     = 1'b0;
    MISS_ADDRESS   = '0;
    MEM_REQ_READY  = 1'b0;
    MEM_RESP_VALID = 1'b0;
    MEM_RESP_DATA  = '0;
    MEM_RESP_ERROR = 1'b0;
    test_reset();
    test_basic();
    test_ready_stall();
    test_gaps();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
